// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, HLT opcode, NOP encoding and
// the fetch-stage state type.
package cpu_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;

   localparam logic [3:0]         OPC_HLT = 4'hF;
   localparam logic [INSTR_W-1:0] NOP     = 16'h0000;

   // RUN: normal fetch. DRAIN: discard the response of a request that a
   // redirect overtook. HALT: frozen after an HLT word was fetched.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   // True when the instruction word carries the HLT opcode in its top nibble.
   function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 4] == OPC_HLT;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word and its address.
// Catches a fetch response that arrives while decode is stalled.
// Priority: clear > load > unload. Load together with unload replaces the entry.
module fetch_skid_buf
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic               unload,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [PC_W-1:0]    pc_i,
   output logic               valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [PC_W-1:0]    pc_o
);

   logic               valid_q, valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_q, pc_d;

   // Next entry contents from clear/load/unload.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (unload) begin
         valid_d = 1'b0;
      end
   end

   // Occupancy flag, synchronously reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) valid_q <= 1'b0;
      else        valid_q <= valid_d;
   end

   // Payload register.
   // NOTE: payload has no reset; valid_q qualifies it, so its power-up value is never used.
   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory and feeds the IF/ID register. Honours decode stalls
// through a one-entry skid, drains requests overtaken by a redirect and
// freezes after fetching HLT.
module if_fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   output logic               ifid_valid,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic [PC_W-1:0]    pc,
   output logic               halt_fetched
);

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               outst_q, outst_d;
   logic [PC_W-1:0]    outst_addr_q, outst_addr_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
   logic               halt_q, halt_d;

   logic               accept;
   logic               accept_hlt;
   logic               hold;
   logic               skid_full_next;
   logic               issue;
   logic               skid_clear, skid_load, skid_unload;
   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;

   // The skid always captures the word of the current response at its request address.
   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (skid_clear),
      .load    (skid_load),
      .unload  (skid_unload),
      .instr_i (imem_rdata),
      .pc_i    (outst_addr_q),
      .valid_o (skid_valid),
      .instr_o (skid_instr),
      .pc_o    (skid_pc)
   );

   // Next-state, IF/ID steering and request issue.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      outst_d        = outst_q;
      outst_addr_d   = outst_addr_q;
      ifid_valid_d   = ifid_valid_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pc_d      = ifid_pc_q;
      halt_d         = halt_q;
      skid_clear     = 1'b0;
      skid_load      = 1'b0;
      skid_unload    = 1'b0;
      issue          = 1'b0;
      hold           = ifid_valid_q && stall_i;
      accept         = imem_rvalid && outst_q && (state_q == RUN);
      accept_hlt     = accept && is_hlt(imem_rdata);
      skid_full_next = 1'b0;

      if (redirect_i) begin
         // Redirect overrides stall, HLT and any response this cycle.
         ifid_valid_d = 1'b0;
         skid_clear   = 1'b1;
         pc_d         = redirect_pc_i;
         halt_d       = 1'b0;
         if (outst_q && !imem_rvalid) begin
            state_d = DRAIN;
         end else begin
            state_d = RUN;
            outst_d = 1'b0;
         end
      end else begin
         // IF/ID and skid movement; runs in every state so a parked HLT still drains.
         if (hold) begin
            skid_load = accept;
         end else if (skid_valid) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = skid_instr;
            ifid_pc_d    = skid_pc;
            skid_unload  = 1'b1;
            skid_load    = accept;
         end else if (accept) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc_d    = outst_addr_q;
         end else begin
            ifid_valid_d = 1'b0;
         end
         skid_full_next = skid_load || (skid_valid && !skid_unload);

         if (state_q == RUN) begin
            if (accept) outst_d = 1'b0;
            if (accept_hlt) begin
               state_d = HALT;
               halt_d  = 1'b1;
            end else if ((!outst_q || imem_rvalid) && !skid_full_next && rst_n) begin
               issue = 1'b1;
            end
         end else if (state_q == DRAIN && imem_rvalid) begin
            // Overtaken response arrives: drop it, resume fetching next cycle.
            state_d = RUN;
            outst_d = 1'b0;
         end

         if (issue) begin
            outst_d      = 1'b1;
            outst_addr_d = pc_q;
            pc_d         = pc_q + PC_W'(1);
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pc_q         <= RST_PC;
         outst_q      <= 1'b0;
         outst_addr_q <= '0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP;
         ifid_pc_q    <= '0;
         halt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         outst_q      <= outst_d;
         outst_addr_q <= outst_addr_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         halt_q       <= halt_d;
      end
   end

   assign imem_req     = issue;
   assign imem_addr    = pc_q;
   assign ifid_valid   = ifid_valid_q;
   assign ifid_instr   = ifid_instr_q;
   assign ifid_pc      = ifid_pc_q;
   assign pc           = pc_q;
   assign halt_fetched = halt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: cycle table for streaming and
// stall/skid, directed redirect/HLT/wrap/reset sequences, then randomized
// stimulus checked by a transaction-level scoreboard.
module tb_if_fetch_stage;
   import cpu_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               stall_i;
   logic               redirect_i;
   logic [PC_W-1:0]    redirect_pc_i;
   logic               ifid_valid;
   logic [INSTR_W-1:0] ifid_instr;
   logic [PC_W-1:0]    ifid_pc;
   logic [PC_W-1:0]    pc;
   logic               halt_fetched;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .ifid_valid    (ifid_valid),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .pc            (pc),
      .halt_fetched  (halt_fetched)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- memory model ----------------
   typedef struct {
      logic [PC_W-1:0] addr;
      int              due;
      int              epoch;
   } mreq_t;

   mreq_t           mq[$];
   int              mem_lat      = 1;
   bit              mem_rand_lat = 0;
   int              mem_mode     = 0;
   bit              hlt_en       = 0;
   logic [PC_W-1:0] hlt_addr     = '0;

   function automatic logic [INSTR_W-1:0] word(input logic [PC_W-1:0] a);
      logic [3:0] opc;
      if (mem_mode == 0) begin
         if (hlt_en && a == hlt_addr) return 16'hF000;
         return 16'h1000 + a;
      end
      opc = (a % 23 == 22) ? 4'hF : 4'(a % 15);
      return {opc, a[11:0]};
   endfunction

   function automatic bit word_is_hlt(input logic [INSTR_W-1:0] w);
      return w[15:12] == 4'hF;
   endfunction

   // ---------------- scoreboard state ----------------
   bit              sb_on       = 0;
   int              epoch       = 0;
   logic            resp_v      = 1'b0;
   logic [PC_W-1:0] resp_addr   = '0;
   int              resp_epoch  = 0;
   logic [PC_W-1:0] exp_req_addr;
   logic [PC_W-1:0] exp_cons_pc;
   bit              cons_halted;
   bit              req_halted;
   logic            exp_halt;
   int              consumed;

   // Start of a cycle: wait the edge, then present any memory response due now.
   task automatic cycle_begin();
      mreq_t e;
      @(posedge clk);
      #1;
      cyc++;
      resp_v      = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = INSTR_W'($urandom);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         e           = mq.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = word(e.addr);
         resp_v      = 1'b1;
         resp_addr   = e.addr;
         resp_epoch  = e.epoch;
      end
   endtask

   // Transaction-level rules: request stream, consumed stream, halt flag.
   task automatic scoreboard();
      check("sb_pc", 32'(pc), 32'(exp_req_addr));
      check("sb_halt_fetched", 32'(halt_fetched), 32'(exp_halt));
      if (imem_req) begin
         check("sb_req_addr", 32'(imem_addr), 32'(exp_req_addr));
         check("sb_req_legal", 32'({redirect_i, req_halted, mq.size() != 0}), 32'h0);
         if (word_is_hlt(word(exp_req_addr))) req_halted = 1;
         exp_req_addr = exp_req_addr + 16'd1;
      end
      if (ifid_valid && !stall_i && !redirect_i) begin
         check("sb_cons_pc", 32'(ifid_pc), 32'(exp_cons_pc));
         check("sb_cons_instr", 32'(ifid_instr), 32'(word(ifid_pc)));
         check("sb_cons_after_hlt", 32'(cons_halted), 32'h0);
         if (word_is_hlt(ifid_instr)) cons_halted = 1;
         exp_cons_pc = exp_cons_pc + 16'd1;
         consumed++;
      end
      if (redirect_i) begin
         exp_req_addr = redirect_pc_i;
         exp_cons_pc  = redirect_pc_i;
         cons_halted  = 0;
         req_halted   = 0;
         exp_halt     = 1'b0;
         epoch++;
      end else if (resp_v && resp_epoch == epoch && word_is_hlt(word(resp_addr))) begin
         exp_halt = 1'b1;
      end
   endtask

   // Mid-cycle: sample outputs, record any request into the memory queue.
   task automatic sample();
      int lat;
      @(negedge clk);
      if (sb_on) scoreboard();
      if (imem_req) begin
         lat = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
         mq.push_back('{addr: imem_addr, due: cyc + lat, epoch: epoch});
      end
   endtask

   // Hold reset for three edges, check reset outputs, leave the bench at cycle 0.
   task automatic do_reset();
      rst_n      = 1'b0;
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      mq.delete();
      repeat (3) begin
         cycle_begin();
         sample();
      end
      check("rst_ifid_valid", 32'(ifid_valid), 32'h0);
      check("rst_ifid_instr", 32'(ifid_instr), 32'h0);
      check("rst_ifid_pc", 32'(ifid_pc), 32'h0);
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_halt", 32'(halt_fetched), 32'h0);
      check("rst_req", 32'(imem_req), 32'h0);
      cycle_begin();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic            stall;
      logic            req;
      logic [PC_W-1:0] addr;
      logic            valid;
      logic [PC_W-1:0] ipc;
      logic [15:0]     instr;
      logic [PC_W-1:0] pcv;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [0:12];
      bit   found;
      int   nreq, nohalt;
      logic [PC_W-1:0] a;

      tbl[0]  = '{1'b0, 1'b1, 16'd0, 1'b0, 16'd0, 16'h0000, 16'd0};
      tbl[1]  = '{1'b0, 1'b1, 16'd1, 1'b0, 16'd0, 16'h0000, 16'd1};
      tbl[2]  = '{1'b0, 1'b1, 16'd2, 1'b1, 16'd0, 16'h1000, 16'd2};
      tbl[3]  = '{1'b0, 1'b1, 16'd3, 1'b1, 16'd1, 16'h1001, 16'd3};
      tbl[4]  = '{1'b0, 1'b1, 16'd4, 1'b1, 16'd2, 16'h1002, 16'd4};
      tbl[5]  = '{1'b0, 1'b1, 16'd5, 1'b1, 16'd3, 16'h1003, 16'd5};
      tbl[6]  = '{1'b0, 1'b1, 16'd6, 1'b1, 16'd4, 16'h1004, 16'd6};
      tbl[7]  = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd5, 16'h1005, 16'd7};
      tbl[8]  = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd5, 16'h1005, 16'd7};
      tbl[9]  = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd5, 16'h1005, 16'd7};
      tbl[10] = '{1'b0, 1'b1, 16'd7, 1'b1, 16'd5, 16'h1005, 16'd7};
      tbl[11] = '{1'b0, 1'b1, 16'd8, 1'b1, 16'd6, 16'h1006, 16'd8};
      tbl[12] = '{1'b0, 1'b1, 16'd9, 1'b1, 16'd7, 16'h1007, 16'd9};

      rst_n         = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      imem_rvalid   = 1'b0;
      imem_rdata    = '0;

      // ---- streaming, then a 3-cycle stall with the skid catching word 6 ----
      mem_mode = 0;
      mem_lat  = 1;
      do_reset();
      for (int i = 0; i <= 12; i++) begin
         stall_i = tbl[i].stall;
         sample();
         check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
         if (tbl[i].req) check($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
         check($sformatf("tbl%0d_valid", i), 32'(ifid_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            check($sformatf("tbl%0d_ifid_pc", i), 32'(ifid_pc), 32'(tbl[i].ipc));
            check($sformatf("tbl%0d_ifid_instr", i), 32'(ifid_instr), 32'(tbl[i].instr));
         end
         check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].pcv));
         cycle_begin();
      end
      stall_i = 1'b0;

      // ---- redirect overtaking an outstanding request (latency 3) ----
      do_reset();
      mem_lat = 3;
      found   = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         sample();
         if (imem_req && imem_addr == 16'h0003) found = 1;
         cycle_begin();
      end
      check("t3_req3_seen", 32'(found), 32'h1);
      redirect_i    = 1'b1;
      redirect_pc_i = 16'h0040;
      sample();
      check("t3_redirect_noreq", 32'(imem_req), 32'h0);
      cycle_begin();
      redirect_i = 1'b0;
      sample();
      check("t3_drain_noreq", 32'(imem_req), 32'h0);
      check("t3_drain_valid", 32'(ifid_valid), 32'h0);
      check("t3_drain_pc", 32'(pc), 32'h40);
      cycle_begin();
      sample();
      check("t3_discard_noreq", 32'(imem_req), 32'h0);
      check("t3_discard_valid", 32'(ifid_valid), 32'h0);
      cycle_begin();
      sample();
      check("t3_restart_req", 32'(imem_req), 32'h1);
      check("t3_restart_addr", 32'(imem_addr), 32'h40);
      check("t3_restart_valid", 32'(ifid_valid), 32'h0);
      cycle_begin();
      for (int i = 0; i < 3; i++) begin
         sample();
         check($sformatf("t3_wait%0d_valid", i), 32'(ifid_valid), 32'h0);
         cycle_begin();
      end
      sample();
      check("t3_first_valid", 32'(ifid_valid), 32'h1);
      check("t3_first_pc", 32'(ifid_pc), 32'h40);
      check("t3_first_instr", 32'(ifid_instr), 32'h1040);
      cycle_begin();

      // ---- HLT at 0x0008, frozen for 20 cycles, then redirect to 0x0002 ----
      hlt_en   = 1;
      hlt_addr = 16'h0008;
      mem_lat  = 1;
      do_reset();
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         sample();
         if (ifid_valid && ifid_pc == 16'h0008) found = 1;
         else cycle_begin();
      end
      check("t4_hlt_seen", 32'(found), 32'h1);
      check("t4_hlt_instr", 32'(ifid_instr), 32'hF000);
      check("t4_halt_flag", 32'(halt_fetched), 32'h1);
      check("t4_halt_pc", 32'(pc), 32'h9);
      check("t4_halt_noreq", 32'(imem_req), 32'h0);
      cycle_begin();
      nreq   = 0;
      nohalt = 0;
      repeat (20) begin
         sample();
         if (imem_req) nreq++;
         if (!halt_fetched || pc != 16'h0009) nohalt++;
         cycle_begin();
      end
      check("t4_frozen_reqs", 32'(nreq), 32'h0);
      check("t4_frozen_state", 32'(nohalt), 32'h0);
      redirect_i    = 1'b1;
      redirect_pc_i = 16'h0002;
      sample();
      check("t4_redirect_noreq", 32'(imem_req), 32'h0);
      cycle_begin();
      redirect_i = 1'b0;
      sample();
      check("t4_resume_halt", 32'(halt_fetched), 32'h0);
      check("t4_resume_req", 32'(imem_req), 32'h1);
      check("t4_resume_addr", 32'(imem_addr), 32'h2);
      cycle_begin();
      sample();
      cycle_begin();
      sample();
      check("t4_resume_valid", 32'(ifid_valid), 32'h1);
      check("t4_resume_ifid_pc", 32'(ifid_pc), 32'h2);
      check("t4_resume_instr", 32'(ifid_instr), 32'h1002);
      cycle_begin();
      hlt_en = 0;

      // ---- PC wrap from 0xFFFE ----
      do_reset();
      mem_lat       = 1;
      redirect_i    = 1'b1;
      redirect_pc_i = 16'hFFFE;
      sample();
      cycle_begin();
      redirect_i = 1'b0;
      a = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         sample();
         check($sformatf("t5_wrap%0d_req", i), 32'(imem_req), 32'h1);
         check($sformatf("t5_wrap%0d_addr", i), 32'(imem_addr), 32'(a));
         a = a + 16'd1;
         cycle_begin();
      end

      // ---- redirect and rvalid in the same cycle, then reset mid-request ----
      do_reset();
      mem_lat = 2;
      sample();
      cycle_begin();
      sample();
      cycle_begin();
      redirect_i    = 1'b1;
      redirect_pc_i = 16'h0020;
      sample();
      check("t5_same_noreq", 32'(imem_req), 32'h0);
      cycle_begin();
      redirect_i = 1'b0;
      sample();
      check("t5_same_req", 32'(imem_req), 32'h1);
      check("t5_same_addr", 32'(imem_addr), 32'h20);
      check("t5_same_valid", 32'(ifid_valid), 32'h0);
      mem_lat = 3;
      cycle_begin();
      sample();
      check("t5_same_wait_valid", 32'(ifid_valid), 32'h0);
      cycle_begin();
      sample();
      check("t5_next_req", 32'(imem_req), 32'h1);
      check("t5_next_addr", 32'(imem_addr), 32'h21);
      cycle_begin();
      rst_n = 1'b0;
      sample();
      check("t5_pre_rst_valid", 32'(ifid_valid), 32'h1);
      check("t5_pre_rst_pc", 32'(ifid_pc), 32'h20);
      check("t5_in_rst_noreq", 32'(imem_req), 32'h0);
      cycle_begin();
      sample();
      check("t5_rst_valid", 32'(ifid_valid), 32'h0);
      check("t5_rst_instr", 32'(ifid_instr), 32'h0);
      check("t5_rst_ifid_pc", 32'(ifid_pc), 32'h0);
      check("t5_rst_pc", 32'(pc), 32'h0);
      check("t5_rst_halt", 32'(halt_fetched), 32'h0);
      cycle_begin();
      rst_n = 1'b1;
      sample();
      check("t5_stray_rvalid_present", 32'(imem_rvalid), 32'h1);
      check("t5_post_rst_req", 32'(imem_req), 32'h1);
      check("t5_post_rst_addr", 32'(imem_addr), 32'h0);
      cycle_begin();
      sample();
      check("t5_stray_ignored", 32'(ifid_valid), 32'h0);
      cycle_begin();
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         sample();
         if (ifid_valid) found = 1;
         else cycle_begin();
      end
      check("t5_post_rst_delivered", 32'(found), 32'h1);
      check("t5_post_rst_ifid_pc", 32'(ifid_pc), 32'h0);
      check("t5_post_rst_instr", 32'(ifid_instr), 32'h1000);
      cycle_begin();

      // ---- randomized stimulus against the scoreboard ----
      mem_mode     = 1;
      mem_rand_lat = 1;
      do_reset();
      epoch        = 0;
      exp_req_addr = 16'h0000;
      exp_cons_pc  = 16'h0000;
      cons_halted  = 0;
      req_halted   = 0;
      exp_halt     = 1'b0;
      consumed     = 0;
      sb_on        = 1;
      for (int i = 0; i < 3000; i++) begin
         stall_i    = ($urandom_range(0, 99) < 30);
         redirect_i = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 3) == 0) redirect_pc_i = 16'hFFF0 + 16'($urandom_range(0, 15));
         else                           redirect_pc_i = PC_W'($urandom);
         sample();
         cycle_begin();
      end
      sb_on      = 0;
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      check("rand_progress", 32'(consumed >= 100), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
